// File: rtl/actuator_tcdm_bridge_pkg.sv
// actuator_package: default bridge constants and the TCDM request payload type
package actuator_package;
    localparam int ACT_TCDM_MP        = 4;
    localparam int ACT_TCDM_DEPTH     = 4;
    localparam int ACT_TCDM_MAX_OUTST = 4;
    localparam int ACT_TCDM_AW        = 32;
    localparam int ACT_TCDM_DW        = 32;

    typedef struct packed {
        logic [ACT_TCDM_AW-1:0]   add;
        logic                     wen;
        logic [ACT_TCDM_DW/8-1:0] be;
        logic [ACT_TCDM_DW-1:0]   data;
    } act_tcdm_req_t;
endpackage

// File: rtl/actuator_tcdm_fifo.sv
// actuator_tcdm_fifo: per-channel request FIFO with synchronous clear
module actuator_tcdm_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    assign data_o  = mem_q[rptr_q];
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

    always_comb begin
        wptr_d = clear_i ? '0 : push_i ? wptr_q + PW'(1) : wptr_q;
        rptr_d = clear_i ? '0 : pop_i ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = clear_i ? '0 : cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/actuator_tcdm_bridge.sv
// actuator_tcdm_bridge: buffered multi-port TCDM master; ACTUATOR_TCDM_STATS_EN adds stall_cnt_o
module actuator_tcdm_bridge
    import actuator_package::*;
#(
    parameter int MP        = ACT_TCDM_MP,
    parameter int DEPTH     = ACT_TCDM_DEPTH,
    parameter int MAX_OUTST = ACT_TCDM_MAX_OUTST,
    parameter int AW        = ACT_TCDM_AW,
    parameter int DW        = ACT_TCDM_DW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic [MP-1:0]      in_req,
    output logic [MP-1:0]      in_gnt,
    input  logic [MP*AW-1:0]   in_add,
    input  logic [MP-1:0]      in_wen,
    input  logic [MP*DW/8-1:0] in_be,
    input  logic [MP*DW-1:0]   in_data,
    output logic [MP*DW-1:0]   in_r_data,
    output logic [MP-1:0]      in_r_valid,
    output logic [MP-1:0]      tcdm_req,
    input  logic [MP-1:0]      tcdm_gnt,
    output logic [MP*AW-1:0]   tcdm_add,
    output logic [MP-1:0]      tcdm_wen,
    output logic [MP*DW/8-1:0] tcdm_be,
    output logic [MP*DW-1:0]   tcdm_data,
    input  logic [MP*DW-1:0]   tcdm_r_data,
    input  logic [MP-1:0]      tcdm_r_valid,
    output logic               busy_o,
    output logic               err_o
`ifdef ACTUATOR_TCDM_STATS_EN
    ,
    output logic [MP*16-1:0]   stall_cnt_o
`endif
);
    localparam int BW = DW / 8;
    localparam int W  = AW + 1 + BW + DW;
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [MP-1:0] spur, busy_v;
    logic          err_q, err_d;

    assign in_r_valid = tcdm_r_valid;
    assign in_r_data  = tcdm_r_data;
    assign busy_o     = |busy_v;
    assign err_o      = err_q;

    for (genvar c = 0; c < MP; c++) begin : g_ch
        logic          full, empty, push, pop;
        logic [W-1:0]  head;
        logic [OW-1:0] outst_q, outst_d;

        assign in_gnt[c] = !full && !rst_i;
        assign push      = in_req[c] && in_gnt[c];
        assign pop       = tcdm_req[c] && tcdm_gnt[c];
        // gated by registered state only, so the head is held stable until granted
        assign tcdm_req[c] = !empty && outst_q < OW'(MAX_OUTST) && !clear_i && !rst_i;
        assign spur[c]     = tcdm_r_valid[c] && outst_q == '0;
        assign busy_v[c]   = !empty || outst_q != '0;
        assign {tcdm_add[c*AW +: AW], tcdm_wen[c], tcdm_be[c*BW +: BW], tcdm_data[c*DW +: DW]} = head;

        actuator_tcdm_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (push),
            .data_i  ({in_add[c*AW +: AW], in_wen[c], in_be[c*BW +: BW], in_data[c*DW +: DW]}),
            .pop_i   (pop),
            .data_o  (head),
            .full_o  (full),
            .empty_o (empty)
        );

        always_comb outst_d = outst_q + OW'(pop) - OW'(tcdm_r_valid[c] && !spur[c]);

        always_ff @(posedge clk_i) begin
            if (rst_i) outst_q <= '0;
            else outst_q <= outst_d;
        end

`ifdef ACTUATOR_TCDM_STATS_EN
        logic [15:0] stall_q, stall_d;

        always_comb stall_d = clear_i ? '0 :
                              (tcdm_req[c] && !tcdm_gnt[c] && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) stall_q <= '0;
            else stall_q <= stall_d;
        end

        assign stall_cnt_o[c*16 +: 16] = stall_q;
`endif
    end

    always_comb err_d = clear_i ? 1'b0 : err_q || |spur;

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else err_q <= err_d;
    end
endmodule

// File: tb/tb_actuator_tcdm_bridge.sv
// tb_actuator_tcdm_bridge: scoreboard bench for actuator_tcdm_bridge (ACTUATOR_TCDM_STATS_EN optional)
module tb_actuator_tcdm_bridge;
    import actuator_package::*;

    localparam int MP = 4, DEPTH = 4, MAX_OUTST = 2, AW = 32, DW = 32, BW = DW / 8;

    logic clk = 1'b0;
    logic rst_i, clear_i;
    logic [MP-1:0]    in_req, in_gnt, in_wen, in_r_valid;
    logic [MP*AW-1:0] in_add, tcdm_add;
    logic [MP*BW-1:0] in_be, tcdm_be;
    logic [MP*DW-1:0] in_data, in_r_data, tcdm_data, tcdm_r_data;
    logic [MP-1:0]    tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic             busy_o, err_o;
`ifdef ACTUATOR_TCDM_STATS_EN
    logic [MP*16-1:0] stall_cnt_o;
`endif

    logic [MP-1:0] man_rv, auto_rv, auto_en, pend_fire;
    logic [DW-1:0] man_data [MP];
    logic [DW-1:0] auto_data [MP];

    act_tcdm_req_t exp_req [MP][$];
    logic [DW-1:0] exp_rsp [MP][$];
    int n_pass = 0, n_chk = 0, auto_k = 0;

    always #5 clk = ~clk;

    actuator_tcdm_bridge #(.MP(MP), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .AW(AW), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .in_req       (in_req),
        .in_gnt       (in_gnt),
        .in_add       (in_add),
        .in_wen       (in_wen),
        .in_be        (in_be),
        .in_data      (in_data),
        .in_r_data    (in_r_data),
        .in_r_valid   (in_r_valid),
        .tcdm_req     (tcdm_req),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_data    (tcdm_data),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .busy_o       (busy_o),
        .err_o        (err_o)
`ifdef ACTUATOR_TCDM_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always_comb begin
        tcdm_r_valid = man_rv | auto_rv;
        tcdm_r_data  = '0;
        for (int c = 0; c < MP; c++) tcdm_r_data[c*DW +: DW] = auto_rv[c] ? auto_data[c] : man_data[c];
    end

    task automatic check(string nm, logic [127:0] act, logic [127:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, want);
    endtask

    task automatic fail(string nm);
        n_chk++;
        $display("FAIL %s: output with no expected entry", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_req(int c, logic [AW-1:0] a, logic w, logic [DW-1:0] d, bit acc);
        act_tcdm_req_t e;
        in_req[c] = 1'b1;
        in_add[c*AW +: AW] = a;
        in_wen[c] = w;
        in_be[c*BW +: BW] = '1;
        in_data[c*DW +: DW] = d;
        e.add = a;
        e.wen = w;
        e.be = '1;
        e.data = d;
        if (acc) exp_req[c].push_back(e);
    endtask

    task automatic man_resp(int c, logic [DW-1:0] d);
        man_rv[c] = 1'b1;
        man_data[c] = d;
        exp_rsp[c].push_back(d);
    endtask

    // monitor: every granted request and every forwarded response is matched against the scoreboard
    always @(negedge clk) begin
        for (int c = 0; c < MP; c++) begin
            pend_fire[c] = tcdm_req[c] && tcdm_gnt[c];
            if (pend_fire[c]) begin
                if (exp_req[c].size() == 0) fail("unexpected_tcdm_req");
                else check("req_payload", {tcdm_add[c*AW +: AW], tcdm_wen[c], tcdm_be[c*BW +: BW], tcdm_data[c*DW +: DW]},
                           exp_req[c].pop_front());
            end
            if (in_r_valid[c]) begin
                if (exp_rsp[c].size() == 0) fail("unexpected_in_r_valid");
                else check("rsp_data", in_r_data[c*DW +: DW], exp_rsp[c].pop_front());
            end
        end
    end

    // auto responder: answers each grant one cycle later on enabled channels
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < MP; c++) begin
            auto_rv[c] = auto_en[c] && pend_fire[c];
            if (auto_rv[c]) begin
                auto_data[c] = 32'hA5A5_0000 + auto_k;
                exp_rsp[c].push_back(auto_data[c]);
                auto_k++;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0;
        in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        tcdm_gnt = '0; man_rv = '0; auto_rv = '0; auto_en = '0; pend_fire = '0;
        for (int c = 0; c < MP; c++) begin man_data[c] = '0; auto_data[c] = '0; end
        repeat (2) step();
        mid();
        check("rst_in_gnt", in_gnt, 4'h0);
        check("rst_tcdm_req", tcdm_req, 4'h0);
        step(); rst_i = 1'b0; mid();
        check("post_rst_in_gnt", in_gnt, 4'hF);
        check("post_rst_tcdm_req", tcdm_req, 4'h0);
        check("post_rst_busy", busy_o, 1'b0);
        check("post_rst_err", err_o, 1'b0);

        // single read on ch0
        step(); tcdm_gnt[0] = 1'b1; push_req(0, 32'h1000, 1'b1, 32'h0, 1'b1); mid();
        check("t1_in_gnt", in_gnt[0], 1'b1);
        check("t1_no_bypass", tcdm_req[0], 1'b0);
        step(); in_req[0] = 1'b0; mid();
        check("t1_req_latency", tcdm_req[0], 1'b1);
        check("t1_busy", busy_o, 1'b1);
        step(); man_resp(0, 32'hDEAD_BEEF); mid();
        check("t1_rvalid", in_r_valid[0], 1'b1);
        check("t1_busy_outst", busy_o, 1'b1);
        step(); man_rv[0] = 1'b0; mid();
        check("t1_busy_fall", busy_o, 1'b0);

        // full FIFO on ch1, then drain at full rate
        for (int k = 0; k < 5; k++) begin
            step(); push_req(1, 32'h2000 + 4 * k, 1'b0, 32'h1111_0000 + k, k < 4); mid();
            check("t2_in_gnt", in_gnt[1], k < 4);
            if (k > 0) check("t2_stall_req", tcdm_req[1], 1'b1);
        end
        step(); in_req[1] = 1'b0; tcdm_gnt[1] = 1'b1; auto_en[1] = 1'b1; mid();
        check("t2_full_on_pop", in_gnt[1], 1'b0);
        check("t2_first_req", tcdm_req[1], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(); mid();
            check("t2_throughput", tcdm_req[1], 1'b1);
            if (k == 0) check("t2_gnt_back", in_gnt[1], 1'b1);
        end
        step(); mid();
        check("t2_drained", tcdm_req[1], 1'b0);
        step(); mid();
        check("t2_busy_fall", busy_o, 1'b0);
        check("t2_queue", exp_req[1].size(), 0);
        step(); tcdm_gnt[1] = 1'b0; auto_en[1] = 1'b0;

        // outstanding cap on ch0
        step(); push_req(0, 32'h3000, 1'b1, 32'h0, 1'b1); mid();
        check("t3_p0", tcdm_req[0], 1'b0);
        step(); push_req(0, 32'h3004, 1'b1, 32'h0, 1'b1); mid();
        check("t3_p1", tcdm_req[0], 1'b1);
        step(); push_req(0, 32'h3008, 1'b1, 32'h0, 1'b1); mid();
        check("t3_p2", tcdm_req[0], 1'b1);
        step(); in_req[0] = 1'b0; mid();
        check("t3_cap", tcdm_req[0], 1'b0);
        check("t3_busy", busy_o, 1'b1);
        step(); man_resp(0, 32'hC0DE_0001); mid();
        check("t3_cap_hold", tcdm_req[0], 1'b0);
        step(); man_rv[0] = 1'b0; mid();
        check("t3_resume", tcdm_req[0], 1'b1);
        step(); man_resp(0, 32'hC0DE_0002); mid();
        step(); man_resp(0, 32'hC0DE_0003); mid();
        check("t3_empty", tcdm_req[0], 1'b0);
        step(); man_rv[0] = 1'b0; mid();
        check("t3_busy_fall", busy_o, 1'b0);
        step(); tcdm_gnt[0] = 1'b0;

        // spurious response on ch2
        step(); man_resp(2, 32'h5555_AAAA); mid();
        check("t4_err_reg", err_o, 1'b0);
        step(); man_rv[2] = 1'b0; mid();
        check("t4_err_set", err_o, 1'b1);
        check("t4_outst_zero", busy_o, 1'b0);
        repeat (3) step();
        mid();
        check("t4_err_sticky", err_o, 1'b1);
        check("t4_still_idle", busy_o, 1'b0);
        step(); clear_i = 1'b1; mid();
        step(); clear_i = 1'b0; mid();
        check("t4_err_clear", err_o, 1'b0);

        // clear with queued and outstanding traffic on ch3
        for (int k = 0; k < 4; k++) begin
            step(); push_req(3, 32'h4000 + 4 * k, 1'b1, 32'h0, 1'b1); mid();
        end
        step(); in_req[3] = 1'b0; tcdm_gnt[3] = 1'b1; mid();
        step(); tcdm_gnt[3] = 1'b0; mid();
        check("t5_pending_req", tcdm_req[3], 1'b1);
        step(); clear_i = 1'b1; exp_req[3].delete(); mid();
        check("t5_clear_req_low", tcdm_req[3], 1'b0);
        step(); clear_i = 1'b0; man_resp(3, 32'h7777_8888); mid();
        check("t5_fifo_empty", tcdm_req[3], 1'b0);
        check("t5_busy_outst", busy_o, 1'b1);
        check("t5_forwarded", in_r_valid[3], 1'b1);
        step(); man_rv[3] = 1'b0; mid();
        check("t5_busy_fall", busy_o, 1'b0);
        check("t5_no_err", err_o, 1'b0);

`ifdef ACTUATOR_TCDM_STATS_EN
        step(); push_req(3, 32'h5000, 1'b1, 32'h0, 1'b1); mid();
        check("s_stall_start", stall_cnt_o[3*16 +: 16], 16'd0);
        step(); in_req[3] = 1'b0;
        repeat (6) step();
        step(); clear_i = 1'b1; exp_req[3].delete(); mid();
        check("s_stall_seven", stall_cnt_o[3*16 +: 16], 16'd7);
        step(); clear_i = 1'b0; mid();
        check("s_stall_clear", stall_cnt_o[3*16 +: 16], 16'd0);
        check("s_idle", busy_o, 1'b0);
`endif

        step(); mid();
        for (int c = 0; c < MP; c++) begin
            check("final_req_queue", exp_req[c].size(), 0);
            check("final_rsp_queue", exp_rsp[c].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
